// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing types, mode constants and counter width.
package vga_pkg;

   localparam int VGA_CNT_W   = 11;
   localparam int VGA_CNT_MAX = 2 ** VGA_CNT_W;
   localparam int VGA_RGB_W   = 12;

   typedef struct packed {
      logic [VGA_CNT_W-1:0] active;
      logic [VGA_CNT_W-1:0] fp;
      logic [VGA_CNT_W-1:0] sync;
      logic [VGA_CNT_W-1:0] bp;
   } timing_t;

   localparam timing_t H_1024X768_60 = '{active: 11'd1024, fp: 11'd24, sync: 11'd136, bp: 11'd160};
   localparam timing_t V_1024X768_60 = '{active: 11'd768,  fp: 11'd3,  sync: 11'd6,   bp: 11'd29};
   localparam timing_t H_800X600_60  = '{active: 11'd800,  fp: 11'd40, sync: 11'd128, bp: 11'd88};
   localparam timing_t V_800X600_60  = '{active: 11'd600,  fp: 11'd1,  sync: 11'd4,   bp: 11'd23};

   function automatic int timing_total(timing_t t);
      return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
   endfunction

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - pixel pipeline bundle between timing generator and drawing stages.
interface vga_if;
   import vga_pkg::*;

   logic [VGA_CNT_W-1:0] hcount;
   logic [VGA_CNT_W-1:0] vcount;
   logic                 hsync;
   logic                 vsync;
   logic                 hblnk;
   logic                 vblnk;
   logic [VGA_RGB_W-1:0] rgb;

   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/vga_timing_axis.sv
// rtl/vga_timing_axis.sv - one timing axis: counter with sync/blank decode.
// Sync and blank are decoded from the next count so they always match the count shown.
module vga_timing_axis
   import vga_pkg::*;
#(
   parameter int ACTIVE = 1024,
   parameter int FP     = 24,
   parameter int SYNC   = 136,
   parameter int BP     = 160,
   parameter bit POL    = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 step,
   output logic [VGA_CNT_W-1:0] count,
   output logic                 wrap_next,
   output logic                 sync,
   output logic                 blnk,
   output logic                 blnk_next
);

   localparam int TOTAL = ACTIVE + FP + SYNC + BP;
   localparam int EW    = VGA_CNT_W + 1;

   localparam logic [VGA_CNT_W-1:0] LAST      = VGA_CNT_W'(TOTAL - 1);
   localparam logic [EW-1:0]        ACTIVE_E  = EW'(ACTIVE);
   localparam logic [EW-1:0]        SYNC_LO_E = EW'(ACTIVE + FP);
   localparam logic [EW-1:0]        SYNC_HI_E = EW'(ACTIVE + FP + SYNC);

   generate
      if (TOTAL > VGA_CNT_MAX || ACTIVE == 0 || SYNC == 0) begin : g_bad_timing
         $error("vga_timing_axis: total %0d exceeds %0d or zero active/sync width", TOTAL, VGA_CNT_MAX);
      end
   endgenerate

   logic [VGA_CNT_W-1:0] count_q;
   logic [VGA_CNT_W-1:0] count_d;
   logic                 sync_q;
   logic                 sync_d;
   logic                 blnk_q;
   logic                 blnk_d;
   logic [EW-1:0]        count_e;

   always_comb begin
      count_d = count_q;
      if (step) begin
         count_d = (count_q == LAST) ? '0 : count_q + VGA_CNT_W'(1);
      end
      count_e = {1'b0, count_d};
      blnk_d  = (count_e >= ACTIVE_E);
      sync_d  = ((count_e >= SYNC_LO_E) && (count_e < SYNC_HI_E)) ? POL : !POL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         sync_q  <= !POL;
         blnk_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         sync_q  <= sync_d;
         blnk_q  <= blnk_d;
      end
   end

   assign count     = count_q;
   assign wrap_next = (count_q == LAST);
   assign sync      = sync_q;
   assign blnk      = blnk_q;
   assign blnk_next = blnk_d;

endmodule

// File: rtl/vga_timing_param.sv
// rtl/vga_timing_param.sv - parametrised VGA timing generator with ce, de, strobes, frame counter.
module vga_timing_param
   import vga_pkg::*;
#(
   parameter int H_ACTIVE    = int'(H_1024X768_60.active),
   parameter int H_FP        = int'(H_1024X768_60.fp),
   parameter int H_SYNC      = int'(H_1024X768_60.sync),
   parameter int H_BP        = int'(H_1024X768_60.bp),
   parameter int V_ACTIVE    = int'(V_1024X768_60.active),
   parameter int V_FP        = int'(V_1024X768_60.fp),
   parameter int V_SYNC      = int'(V_1024X768_60.sync),
   parameter int V_BP        = int'(V_1024X768_60.bp),
   parameter bit HSYNC_POL   = 1'b1,
   parameter bit VSYNC_POL   = 1'b1,
   parameter int FRAME_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ce,
   vga_if.out                     out,
   output logic                   de,
   output logic                   line_start,
   output logic                   frame_start,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   generate
      if (FRAME_CNT_W < 1) begin : g_bad_frame_cnt_w
         $error("vga_timing_param: FRAME_CNT_W must be at least 1");
      end
   endgenerate

   logic [VGA_CNT_W-1:0] h_count;
   logic [VGA_CNT_W-1:0] v_count;
   logic                 h_wrap;
   logic                 v_wrap;
   logic                 h_sync;
   logic                 v_sync;
   logic                 h_blnk;
   logic                 v_blnk;
   logic                 h_blnk_next;
   logic                 v_blnk_next;
   logic                 v_step;

   // Lines advance only on the pixel step that wraps the horizontal counter.
   assign v_step = ce && h_wrap;

   vga_timing_axis #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (HSYNC_POL)
   ) u_h_axis (
      .clk       (clk),
      .rst       (rst),
      .step      (ce),
      .count     (h_count),
      .wrap_next (h_wrap),
      .sync      (h_sync),
      .blnk      (h_blnk),
      .blnk_next (h_blnk_next)
   );

   vga_timing_axis #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (VSYNC_POL)
   ) u_v_axis (
      .clk       (clk),
      .rst       (rst),
      .step      (v_step),
      .count     (v_count),
      .wrap_next (v_wrap),
      .sync      (v_sync),
      .blnk      (v_blnk),
      .blnk_next (v_blnk_next)
   );

   logic                   de_q;
   logic                   de_d;
   logic                   line_start_q;
   logic                   line_start_d;
   logic                   frame_start_q;
   logic                   frame_start_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q;
   logic [FRAME_CNT_W-1:0] frame_cnt_d;

   // Strobes are derived from this cycle's ce, so a held ce can never stretch them.
   always_comb begin
      de_d          = !(h_blnk_next || v_blnk_next);
      line_start_d  = ce && h_wrap;
      frame_start_d = ce && h_wrap && v_wrap;
      frame_cnt_d   = frame_cnt_q;
      if (frame_start_d) begin
         frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         de_q          <= 1'b1;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         de_q          <= de_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign out.hcount  = h_count;
   assign out.vcount  = v_count;
   assign out.hsync   = h_sync;
   assign out.vsync   = v_sync;
   assign out.hblnk   = h_blnk;
   assign out.vblnk   = v_blnk;
   assign out.rgb     = '0;
   assign de          = de_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_param.sv
// tb/tb_vga_timing_param.sv - scoreboard bench for vga_timing_param, small and default modes.
module tb_vga_timing_param;

   typedef struct {
      int h;
      int v;
      int hsync;
      int vsync;
      int hblnk;
      int vblnk;
      int de;
      int ls;
      int fs;
      int fc;
   } exp_t;

   localparam int NCYC = 6000;

   logic        clk;
   logic        rst;
   logic        ce;
   logic        de_s, ls_s, fs_s;
   logic [1:0]  fc_s;
   logic        de_d, ls_d, fs_d;
   logic [15:0] fc_d;

   int checks;
   int errors;
   exp_t q_s[$];
   exp_t q_d[$];

   vga_if vif_s ();
   vga_if vif_d ();

   vga_timing_param #(
      .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .HSYNC_POL (1'b1), .VSYNC_POL (1'b1), .FRAME_CNT_W (2)
   ) dut_s (
      .clk (clk), .rst (rst), .ce (ce), .out (vif_s),
      .de (de_s), .line_start (ls_s), .frame_start (fs_s), .frame_cnt (fc_s)
   );

   vga_timing_param #(
      .HSYNC_POL (1'b0), .VSYNC_POL (1'b0)
   ) dut_d (
      .clk (clk), .rst (rst), .ce (ce), .out (vif_d),
      .de (de_d), .line_start (ls_d), .frame_start (fs_d), .frame_cnt (fc_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Position is just the number of pixel steps since reset; everything follows from arithmetic.
   function automatic exp_t model(int n, bit stepped, int ha, int hf, int hs, int hb,
                                  int va, int vf, int vs, int vb, bit hp, bit vp, int fcw);
      exp_t m;
      int ht;
      int vt;
      ht = ha + hf + hs + hb;
      vt = va + vf + vs + vb;
      m.h     = n % ht;
      m.v     = (n / ht) % vt;
      m.fc    = (n / (ht * vt)) % (1 << fcw);
      m.hblnk = (m.h >= ha) ? 1 : 0;
      m.vblnk = (m.v >= va) ? 1 : 0;
      m.hsync = (m.h >= ha + hf && m.h < ha + hf + hs) ? int'(hp) : int'(!hp);
      m.vsync = (m.v >= va + vf && m.v < va + vf + vs) ? int'(vp) : int'(!vp);
      m.de    = (m.hblnk == 0 && m.vblnk == 0) ? 1 : 0;
      m.ls    = (stepped && m.h == 0) ? 1 : 0;
      m.fs    = (stepped && m.h == 0 && m.v == 0) ? 1 : 0;
      return m;
   endfunction

   task automatic chk(string nm, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
      end
   endtask

   // Stimulus: drive on negedge, push the expectation for the coming posedge.
   initial begin
      int  n;
      bit  rst_v;
      bit  ce_v;
      bit  stepped;
      checks = 0;
      errors = 0;
      n      = 0;
      rst    = 1'b1;
      ce     = 1'b0;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         rst_v = (cyc == 0) || (cyc == 4000) || (cyc > 3500 && $urandom_range(0, 399) == 0);
         if (cyc < 3000)      ce_v = 1'b1;
         else if (cyc < 3400) ce_v = (cyc % 4 == 0);
         else if (cyc < 3500) ce_v = 1'b0;
         else                 ce_v = ($urandom_range(0, 9) < 7);
         if (rst_v && $urandom_range(0, 1) == 1) ce_v = 1'b1;
         rst = rst_v;
         ce  = ce_v;
         stepped = 1'b0;
         if (rst_v) begin
            n = 0;
         end else if (ce_v) begin
            n++;
            stepped = 1'b1;
         end
         q_s.push_back(model(n, stepped, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1, 2));
         q_d.push_back(model(n, stepped, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0, 16));
      end
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", q_s.size() + q_d.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Monitor: outputs are valid every cycle; compare just after each active edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q_s.size() > 0) begin
            e = q_s.pop_front();
            chk("s_hcount", int'(vif_s.hcount), e.h);
            chk("s_vcount", int'(vif_s.vcount), e.v);
            chk("s_hsync", int'(vif_s.hsync), e.hsync);
            chk("s_vsync", int'(vif_s.vsync), e.vsync);
            chk("s_hblnk", int'(vif_s.hblnk), e.hblnk);
            chk("s_vblnk", int'(vif_s.vblnk), e.vblnk);
            chk("s_de", int'(de_s), e.de);
            chk("s_line_start", int'(ls_s), e.ls);
            chk("s_frame_start", int'(fs_s), e.fs);
            chk("s_frame_cnt", int'(fc_s), e.fc);
            chk("s_rgb", int'(vif_s.rgb), 0);
         end
         if (q_d.size() > 0) begin
            e = q_d.pop_front();
            chk("d_hcount", int'(vif_d.hcount), e.h);
            chk("d_vcount", int'(vif_d.vcount), e.v);
            chk("d_hsync", int'(vif_d.hsync), e.hsync);
            chk("d_vsync", int'(vif_d.vsync), e.vsync);
            chk("d_hblnk", int'(vif_d.hblnk), e.hblnk);
            chk("d_vblnk", int'(vif_d.vblnk), e.vblnk);
            chk("d_de", int'(de_d), e.de);
            chk("d_line_start", int'(ls_d), e.ls);
            chk("d_frame_start", int'(fs_d), e.fs);
            chk("d_frame_cnt", int'(fc_d), e.fc);
         end
      end
   end

endmodule
